// File: rtl/sdram_avmm_arbiter_if.sv
// ============================================================================
// Module   : sdram_avmm_arbiter_if
// Brief    : Avalon-MM pipelined-read bus bundle, one instance per port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sdram_avmm_arbiter_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

`default_nettype wire

// File: rtl/sdram_avmm_arbiter.sv
// ============================================================================
// Module   : sdram_avmm_arbiter
// Brief    : Two-master round-robin Avalon-MM arbiter with read-ID FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_avmm_arbiter #(
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4
) (
   input  wire                  clk_riscv,
   input  wire                  rst_n,
   sdram_avmm_arbiter_if.slave  m0,
   sdram_avmm_arbiter_if.slave  m1,
   sdram_avmm_arbiter_if.master s,
   output logic                 err_rdv
);

   localparam int C_PTR_W = $clog2(MAX_OUTST);
   localparam int C_CNT_W = C_PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_last_gnt;
   logic                 r_err_rdv;
   logic                 r_fifo [MAX_OUTST];
   logic [C_PTR_W-1:0]   r_wptr;
   logic [C_PTR_W-1:0]   r_rptr;
   logic [C_CNT_W-1:0]   r_count;

   logic w_req0, w_req1;
   logic w_own0, w_own1;
   logic w_full, w_empty;
   logic w_sel_rd, w_sel_wr;
   logic w_s_read, w_s_write;
   logic w_present, w_acc;
   logic w_push, w_pop, w_head;

   assign w_req0  = m0.read | m0.write;
   assign w_req1  = m1.read | m1.write;
   assign w_own0  = (r_state == ST_OWN0);
   assign w_own1  = (r_state == ST_OWN1);
   assign w_full  = (r_count == C_CNT_W'(MAX_OUTST));
   assign w_empty = (r_count == '0);

   assign w_sel_rd = (w_own0 & m0.read)  | (w_own1 & m1.read);
   assign w_sel_wr = (w_own0 & m0.write) | (w_own1 & m1.write);

   // Read wins over a simultaneous write; a read blocked by a full FIFO issues nothing.
   assign w_s_read  = w_sel_rd & ~w_full;
   assign w_s_write = w_sel_wr & ~w_sel_rd;
   assign w_present = w_s_read | w_s_write;
   assign w_acc     = w_present & ~s.waitrequest;

   assign s.read       = w_s_read;
   assign s.write      = w_s_write;
   assign s.address    = w_own1 ? m1.address    : m0.address;
   assign s.writedata  = w_own1 ? m1.writedata  : m0.writedata;
   assign s.byteenable = w_own1 ? m1.byteenable : m0.byteenable;

   assign m0.waitrequest = ~(w_own0 & w_acc);
   assign m1.waitrequest = ~(w_own1 & w_acc);

   assign w_push = w_s_read & ~s.waitrequest;
   assign w_pop  = s.readdatavalid & ~w_empty;
   assign w_head = r_fifo[r_rptr];

   assign m0.readdatavalid = w_pop & ~w_head;
   assign m1.readdatavalid = w_pop &  w_head;
   assign m0.readdata      = s.readdata;
   assign m1.readdata      = s.readdata;

   assign err_rdv = r_err_rdv;

   // A presented command holds the grant; an owner with nothing on the bus
   // yields when it withdraws or when the other master is waiting.
   always_ff @(posedge clk_riscv or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req0 && (!w_req1 || r_last_gnt)) begin
                  r_state <= ST_OWN0;
               end else if (w_req1) begin
                  r_state <= ST_OWN1;
               end
            end
            ST_OWN0: begin
               if (w_acc) begin
                  r_state    <= ST_IDLE;
                  r_last_gnt <= 1'b0;
               end else if (!w_present && (!w_req0 || w_req1)) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_OWN1: begin
               if (w_acc) begin
                  r_state    <= ST_IDLE;
                  r_last_gnt <= 1'b1;
               end else if (!w_present && (!w_req1 || w_req0)) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Entry holds the issuing master: 0 = m0, 1 = m1.
   always_ff @(posedge clk_riscv or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            r_fifo[i] <= 1'b0;
         end
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_err_rdv <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= w_own1;
            r_wptr         <= r_wptr + C_PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + C_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_W'(1);
            2'b01:   r_count <= r_count - C_CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (s.readdatavalid && w_empty) begin
            r_err_rdv <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sdram_avmm_arbiter.sv
// ============================================================================
// Module   : tb_sdram_avmm_arbiter
// Brief    : Directed vector-table bench for the two-master SDRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_avmm_arbiter;

   localparam int ADDR_W    = 23;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 4;

   logic clk_riscv;
   logic rst_n;
   logic err_rdv;

   int n_checks = 0;
   int n_errors = 0;

   sdram_avmm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   sdram_avmm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
   sdram_avmm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

   sdram_avmm_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_OUTST (MAX_OUTST)
   ) u_dut (
      .clk_riscv (clk_riscv),
      .rst_n     (rst_n),
      .m0        (m0_if.slave),
      .m1        (m1_if.slave),
      .s         (s_if.master),
      .err_rdv   (err_rdv)
   );

   initial clk_riscv = 1'b0;
   always #5 clk_riscv = ~clk_riscv;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        m0_rd, m0_wr, m1_rd, m1_wr, s_wait, s_rdv;
      logic [31:0] s_rdata;
      logic        e_sread, e_swrite, e_w0, e_w1, e_v0, e_v1;
      logic [22:0] e_addr;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_riscv);
      #1;
   endtask

   task automatic clear_inputs();
      m0_if.address = '0; m0_if.read = 1'b0; m0_if.write = 1'b0;
      m0_if.writedata = '0; m0_if.byteenable = '0;
      m1_if.address = '0; m1_if.read = 1'b0; m1_if.write = 1'b0;
      m1_if.writedata = '0; m1_if.byteenable = '0;
      s_if.waitrequest = 1'b0; s_if.readdata = '0; s_if.readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk_riscv);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int  n_acc;
      bit  got;

      rst_n = 1'b0;
      clear_inputs();

      // Alternating grants, then beats routed by issue order.
      tbl[0]  = '{1,0,1,0,0,0,32'h0,          0,0,1,1,0,0,23'h0};
      tbl[1]  = '{1,0,1,0,0,0,32'h0,          1,0,0,1,0,0,23'h10};
      tbl[2]  = '{1,0,1,0,0,0,32'h0,          0,0,1,1,0,0,23'h0};
      tbl[3]  = '{1,0,1,0,0,0,32'h0,          1,0,1,0,0,0,23'h20};
      tbl[4]  = '{1,0,1,0,0,0,32'h0,          0,0,1,1,0,0,23'h0};
      tbl[5]  = '{1,0,1,0,0,0,32'h0,          1,0,0,1,0,0,23'h10};
      tbl[6]  = '{1,0,1,0,0,0,32'h0,          0,0,1,1,0,0,23'h0};
      tbl[7]  = '{1,0,1,0,0,0,32'h0,          1,0,1,0,0,0,23'h20};
      tbl[8]  = '{0,0,0,0,0,1,32'hAAAA0001,   0,0,1,1,1,0,23'h0};
      tbl[9]  = '{0,0,0,0,0,1,32'hBBBB0002,   0,0,1,1,0,1,23'h0};
      tbl[10] = '{0,0,0,0,0,1,32'hCCCC0003,   0,0,1,1,1,0,23'h0};
      tbl[11] = '{0,0,0,0,0,1,32'hDDDD0004,   0,0,1,1,0,1,23'h0};

      // Reset state
      #2;
      chk("rst_sread",  s_if.read, 1'b0);
      chk("rst_swrite", s_if.write, 1'b0);
      chk("rst_w0",     m0_if.waitrequest, 1'b1);
      chk("rst_w1",     m1_if.waitrequest, 1'b1);
      chk("rst_v0",     m0_if.readdatavalid, 1'b0);
      chk("rst_err",    err_rdv, 1'b0);

      // Table: round-robin reads from both masters
      do_reset();
      m0_if.address = 23'h10;
      m1_if.address = 23'h20;
      for (int i = 0; i < 12; i++) begin
         m0_if.read = tbl[i].m0_rd; m0_if.write = tbl[i].m0_wr;
         m1_if.read = tbl[i].m1_rd; m1_if.write = tbl[i].m1_wr;
         s_if.waitrequest   = tbl[i].s_wait;
         s_if.readdatavalid = tbl[i].s_rdv;
         s_if.readdata      = tbl[i].s_rdata;
         #1;
         chk($sformatf("tbl%0d_sread", i),  s_if.read, tbl[i].e_sread);
         chk($sformatf("tbl%0d_swrite", i), s_if.write, tbl[i].e_swrite);
         chk($sformatf("tbl%0d_w0", i),     m0_if.waitrequest, tbl[i].e_w0);
         chk($sformatf("tbl%0d_w1", i),     m1_if.waitrequest, tbl[i].e_w1);
         chk($sformatf("tbl%0d_v0", i),     m0_if.readdatavalid, tbl[i].e_v0);
         chk($sformatf("tbl%0d_v1", i),     m1_if.readdatavalid, tbl[i].e_v1);
         if (tbl[i].e_sread)
            chk($sformatf("tbl%0d_addr", i), s_if.address, tbl[i].e_addr);
         if (tbl[i].e_v0)
            chk($sformatf("tbl%0d_rd0", i), m0_if.readdata, tbl[i].s_rdata);
         if (tbl[i].e_v1)
            chk($sformatf("tbl%0d_rd1", i), m1_if.readdata, tbl[i].s_rdata);
         cyc();
      end
      s_if.readdatavalid = 1'b0;
      #1;
      chk("tbl_err_clean", err_rdv, 1'b0);

      // Single m0 read, beat three cycles after acceptance
      do_reset();
      m0_if.address = 23'h000100; m0_if.read = 1'b1;
      #1; chk("t1_c0_sread", s_if.read, 1'b0);
      cyc();
      #1; chk("t1_c1_sread", s_if.read, 1'b1);
      chk("t1_c1_addr", s_if.address, 23'h000100);
      chk("t1_c1_w0", m0_if.waitrequest, 1'b0);
      cyc();
      m0_if.read = 1'b0;
      #1; chk("t1_c2_sread", s_if.read, 1'b0);
      cyc(); cyc();
      s_if.readdatavalid = 1'b1; s_if.readdata = 32'hDEADBEEF;
      #1;
      chk("t1_v0", m0_if.readdatavalid, 1'b1);
      chk("t1_rd0", m0_if.readdata, 32'hDEADBEEF);
      chk("t1_v1", m1_if.readdatavalid, 1'b0);
      cyc();
      s_if.readdatavalid = 1'b0;

      // m1 write stalled five cycles; grant lock against m0
      do_reset();
      m1_if.address = 23'h0055AA; m1_if.writedata = 32'h12345678;
      m1_if.byteenable = 4'hF; m1_if.write = 1'b1; s_if.waitrequest = 1'b1;
      m0_if.address = 23'h000300;
      #1; chk("t3_c0_swrite", s_if.write, 1'b0);
      cyc();
      for (int k = 1; k <= 5; k++) begin
         if (k == 2) m0_if.read = 1'b1;
         #1;
         chk($sformatf("t3_c%0d_swrite", k), s_if.write, 1'b1);
         chk($sformatf("t3_c%0d_addr", k),   s_if.address, 23'h0055AA);
         chk($sformatf("t3_c%0d_wdata", k),  s_if.writedata, 32'h12345678);
         chk($sformatf("t3_c%0d_w1", k),     m1_if.waitrequest, 1'b1);
         chk($sformatf("t3_c%0d_w0", k),     m0_if.waitrequest, 1'b1);
         cyc();
      end
      s_if.waitrequest = 1'b0;
      #1;
      chk("t3_c6_w1", m1_if.waitrequest, 1'b0);
      chk("t3_c6_swrite", s_if.write, 1'b1);
      cyc();
      m1_if.write = 1'b0;
      #1; chk("t3_c7_sread", s_if.read, 1'b0);
      cyc();
      #1;
      chk("t3_c8_sread", s_if.read, 1'b1);
      chk("t3_c8_addr", s_if.address, 23'h000300);
      chk("t3_c8_w0", m0_if.waitrequest, 1'b0);
      cyc();
      m0_if.read = 1'b0;

      // FIFO full: fifth read stalls, write passes, pop releases the read
      do_reset();
      m0_if.address = 23'h000040; m0_if.read = 1'b1;
      n_acc = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (s_if.read && !s_if.waitrequest && !m0_if.waitrequest) n_acc++;
         cyc();
      end
      chk("t4_accepts", n_acc, 4);
      #1;
      chk("t4_full_sread", s_if.read, 1'b0);
      chk("t4_full_w0", m0_if.waitrequest, 1'b1);
      cyc();
      m1_if.address = 23'h000077; m1_if.writedata = 32'hCAFEF00D;
      m1_if.byteenable = 4'hF; m1_if.write = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (!m1_if.waitrequest) begin
            got = 1'b1;
            chk("t4_wr_swrite", s_if.write, 1'b1);
            chk("t4_wr_addr", s_if.address, 23'h000077);
            chk("t4_wr_w0", m0_if.waitrequest, 1'b1);
         end
         cyc();
         if (got) break;
      end
      chk("t4_wr_accepted", got, 1'b1);
      m1_if.write = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1; chk($sformatf("t4_hold%0d_sread", k), s_if.read, 1'b0);
         cyc();
      end
      s_if.readdatavalid = 1'b1; s_if.readdata = 32'h00000011;
      #1;
      chk("t4_pop_v0", m0_if.readdatavalid, 1'b1);
      chk("t4_pop_sread", s_if.read, 1'b0);
      chk("t4_pop_w0", m0_if.waitrequest, 1'b1);
      cyc();
      s_if.readdatavalid = 1'b0;
      #1;
      chk("t4_rel_sread", s_if.read, 1'b1);
      chk("t4_rel_w0", m0_if.waitrequest, 1'b0);
      chk("t4_rel_addr", s_if.address, 23'h000040);
      cyc();
      m0_if.read = 1'b0;

      // Unexpected beat sets sticky error, cleared only by reset
      do_reset();
      s_if.readdatavalid = 1'b1; s_if.readdata = 32'h00000099;
      #1;
      chk("t5_v0", m0_if.readdatavalid, 1'b0);
      chk("t5_v1", m1_if.readdatavalid, 1'b0);
      chk("t5_err_pre", err_rdv, 1'b0);
      cyc();
      s_if.readdatavalid = 1'b0;
      #1; chk("t5_err_set", err_rdv, 1'b1);
      cyc(); cyc(); cyc();
      #1; chk("t5_err_held", err_rdv, 1'b1);
      rst_n = 1'b0;
      #1; chk("t5_err_rst", err_rdv, 1'b0);

      // Asynchronous reset mid-stall with two reads outstanding
      do_reset();
      m0_if.address = 23'h000500; m0_if.read = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      m0_if.read = 1'b0;
      m1_if.address = 23'h000600; m1_if.read = 1'b1; s_if.waitrequest = 1'b1;
      cyc();
      #1; chk("t6_stall_sread", s_if.read, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_sread", s_if.read, 1'b0);
      chk("t6_rst_w0", m0_if.waitrequest, 1'b1);
      chk("t6_rst_w1", m1_if.waitrequest, 1'b1);
      clear_inputs();
      repeat (2) @(posedge clk_riscv);
      #1;
      rst_n = 1'b1;
      s_if.readdatavalid = 1'b1; s_if.readdata = 32'h00000055;
      #1;
      chk("t6_empty_v0", m0_if.readdatavalid, 1'b0);
      chk("t6_empty_v1", m1_if.readdatavalid, 1'b0);
      cyc();
      s_if.readdatavalid = 1'b0;
      #1; chk("t6_empty_err", err_rdv, 1'b1);
      cyc();
      m0_if.address = 23'h000500; m0_if.read = 1'b1;
      m1_if.address = 23'h000600; m1_if.read = 1'b1;
      cyc();
      #1;
      chk("t6_tie_w0", m0_if.waitrequest, 1'b0);
      chk("t6_tie_w1", m1_if.waitrequest, 1'b1);
      chk("t6_tie_addr", s_if.address, 23'h000500);
      cyc();
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
